dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits downstream of the pipeline's MEM stage. It takes the place of the flat data memory port and sits between the CPU and an off-chip memory with a 256-bit block interface.
- Hits are served combinationally in the same cycle.
- On a miss it raises a stall that freezes the whole pipeline. It then runs an optional dirty-victim writeback and a refill, and releases the stall once the line is resident.

Parameters:
- LINES, 32, number of cache lines; index width = log2(LINES) = 5.
- BLOCK_W, 256, line width in bits (8 words); offset = addr[4:2].
- ADDR_W, 32, byte address width; tag = addr[31:10] (22 bits).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- p1_addr_i  in  32  CPU byte address (EX/MEM ALU result); addr[1:0] ignored.
- p1_data_i  in  32  CPU store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data; valid when a read is present and p1_stall_o=0.
- p1_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- mem_addr_o  out  32  block address, low 5 bits always 0.
- mem_data_o  out  256  victim line for writeback.
- mem_enable_o  out  1  memory request; held high until mem_ack_i.
- mem_write_o  out  1  1 = write block, 0 = read block; qualified by mem_enable_o.
- mem_data_i  in  256  refill block; valid in the cycle mem_ack_i=1.
- mem_ack_i  in  1  single-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - all valid and dirty bits cleared; tag and data arrays left unspecified;
  - state = IDLE;
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p1_data_o=0, p1_stall_o=0.
- Request = p1_MemRead_i | p1_MemWrite_i. If both are asserted, the access is treated as a write; the pipeline never issues this.
- Hit = valid[idx] & (tag[idx] == addr[31:10]).
- Read hit: p1_data_o = word[offset] of the line, combinational; p1_stall_o=0; zero added latency.
- Write hit: the word at offset is written on the next rising edge and dirty[idx] is set; no stall.
- Miss: p1_stall_o rises combinationally in the same cycle. The CPU holds addr, data and the read/write strobes stable while stalled.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE -> MISS: request & !hit.
  - MISS -> WRITEBACK if dirty[idx]. Drive mem_enable_o=1, mem_write_o=1, mem_addr_o={tag[idx], idx, 5'b0}, mem_data_o=line[idx].
  - MISS -> REFILL if !dirty[idx]. Drive mem_enable_o=1, mem_write_o=0, mem_addr_o={addr[31:5], 5'b0}.
  - WRITEBACK -> REFILL on mem_ack_i. Memory outputs switch to the refill read; mem_enable_o stays high.
  - REFILL -> REFILL_DONE on mem_ack_i. Line[idx]=mem_data_i, tag=addr[31:10], valid=1, dirty=0; mem_enable_o drops.
  - REFILL_DONE -> IDLE unconditionally. The access now hits, and in this cycle a read returns data / a write updates the word and sets dirty. p1_stall_o falls in this cycle.
- Memory-side outputs are registered; they change only on state transitions.
- mem_ack_i outside WRITEBACK or REFILL is ignored.
- Miss latency: 1 (MISS) + writeback latency (if dirty) + refill latency + 1 (REFILL_DONE) cycles.
- No request in IDLE: p1_stall_o=0 and p1_data_o holds its last value; no array updates.
- Reset mid-miss: FSM returns to IDLE immediately, mem_enable_o drops, valid bits are cleared. Any in-flight memory transaction is abandoned, and memory must tolerate this.
- Back-to-back misses to the same index with different tags: the second miss evicts the first line; a dirty victim is written back first.

Decomposition:
- Package dcache_pkg holds:
  - state enum (IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE);
  - TAG_W=22, IDX_W=5, OFF_W=3 localparams;
  - tag/idx/offset field-extraction constants.
- Sub-module dcache_sram: tag, valid and dirty arrays plus a 256-bit data array. Asynchronous read, synchronous write enables for whole-line and single-word writes, asynchronous clear of valid and dirty on rst_n_i.

Test Plan:
- Cold read 0x0000_0040, memory block with word0=0x1111_1111 and 2-cycle ack: stall rises in the same cycle, mem_write_o=0, mem_addr_o=0x40; after the ack, p1_data_o=0x1111_1111 in REFILL_DONE and stall falls.
- Write 0xDEAD_BEEF to 0x44, then read 0x44: no stall on either access; read returns 0xDEAD_BEEF and dirty[2]=1.
- Read 0x0000_0444 (same index 2, new tag) with line 2 dirty: WRITEBACK with mem_addr_o=0x40 and mem_data_o word1=0xDEAD_BEEF, then REFILL with mem_addr_o=0x440; stall held throughout.
- Write miss 0x0000_0800 with data 0x0000_00AA: refill, then the word is written; a read of 0x800 returns 0xAA and dirty=1.
- Assert rst_n_i low while in REFILL: mem_enable_o=0 asynchronously, state=IDLE; the next read of 0x40 misses.
- Pulse mem_ack_i while in IDLE: no state change, no array write.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, address field positions and FSM states for the L1 data cache.
package dcache_pkg;
  localparam int LINES   = 32;
  localparam int BLOCK_W = 256;
  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 32;
  localparam int TAG_W   = 22;
  localparam int IDX_W   = 5;
  localparam int OFF_W   = 3;
  localparam int TAG_LSB = 10;
  localparam int IDX_LSB = 5;
  localparam int OFF_LSB = 2;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays with async read, sync line and word writes.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_line_we,
  input  logic [BLOCK_W-1:0] i_line,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_word_we,
  input  logic [OFF_W-1:0]   i_off,
  input  logic [WORD_W-1:0]  i_word,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [BLOCK_W-1:0] o_line
);
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [BLOCK_W-1:0] r_data [LINES];
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we)
      r_dirty[i_idx] <= 1'b1;
  // Tag and data contents are deliberately not reset; valid gates their use.
  always_ff @(posedge clk_i)
    if (i_line_we) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_line;
    end else if (i_word_we)
      r_data[i_idx][i_off*WORD_W +: WORD_W] <= i_word;
  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_line  = r_data[i_idx];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate L1 D-cache with
// combinational hits and a stall-based miss FSM toward a 256-bit block memory.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ADDR_W-1:0]  p1_addr_i,
  input  logic [WORD_W-1:0]  p1_data_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  output logic [WORD_W-1:0]  p1_data_o,
  output logic               p1_stall_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_data_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  input  logic [BLOCK_W-1:0] mem_data_i,
  input  logic               mem_ack_i
);
  state_t             r_state;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [BLOCK_W-1:0] r_mem_data;
  logic [WORD_W-1:0]  r_rdata;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic [TAG_W-1:0]   w_line_tag;
  logic               w_valid;
  logic               w_dirty;
  logic [BLOCK_W-1:0] w_line;
  logic [WORD_W-1:0]  w_word;
  logic               w_req;
  logic               w_rd;
  logic               w_hit;
  logic               w_serve;
  logic               w_line_we;
  logic               w_word_we;
  logic               w_unused;
  assign w_tag      = p1_addr_i[ADDR_W-1:TAG_LSB];
  assign w_idx      = p1_addr_i[TAG_LSB-1:IDX_LSB];
  assign w_off      = p1_addr_i[IDX_LSB-1:OFF_LSB];
  assign w_unused   = ^p1_addr_i[OFF_LSB-1:0];
  assign w_req      = p1_MemRead_i | p1_MemWrite_i;
  assign w_rd       = p1_MemRead_i & ~p1_MemWrite_i;
  assign w_hit      = w_valid & (w_line_tag == w_tag);
  assign w_word     = w_line[w_off*WORD_W +: WORD_W];
  assign w_serve    = (r_state == IDLE) | (r_state == REFILL_DONE);
  assign w_line_we  = (r_state == REFILL) & mem_ack_i;
  assign w_word_we  = p1_MemWrite_i & w_hit & w_serve;
  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .i_idx     (w_idx),
    .i_line_we (w_line_we),
    .i_line    (mem_data_i),
    .i_tag     (w_tag),
    .i_word_we (w_word_we),
    .i_off     (w_off),
    .i_word    (p1_data_i),
    .o_tag     (w_line_tag),
    .o_valid   (w_valid),
    .o_dirty   (w_dirty),
    .o_line    (w_line)
  );
  // Stall is combinational so the pipeline freezes in the very cycle of the miss.
  assign p1_stall_o   = (r_state == IDLE) ? (w_req & ~w_hit) : (r_state != REFILL_DONE);
  assign p1_data_o    = (w_rd & w_hit) ? w_word : r_rdata;
  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_rdata <= '0;
    else if (w_rd & w_hit & ~p1_stall_o) r_rdata <= w_word;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else
      case (r_state)
        IDLE: if (w_req & ~w_hit) r_state <= MISS;
        MISS: begin
          r_mem_en <= 1'b1;
          if (w_dirty) begin
            r_state    <= WRITEBACK;
            r_mem_we   <= 1'b1;
            r_mem_addr <= {w_line_tag, w_idx, {IDX_LSB{1'b0}}};
            r_mem_data <= w_line;
          end else begin
            r_state    <= REFILL;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {p1_addr_i[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          r_state    <= REFILL;
          r_mem_we   <= 1'b0;
          r_mem_addr <= {p1_addr_i[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
        end
        REFILL: if (mem_ack_i) begin
          r_state  <= REFILL_DONE;
          r_mem_en <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
endmodule
